// File: rtl/etapa_escritura_alu_if.sv
// Bundle between the ALU, the writeback stage and the register file.
// Upstream handshake, write port, flags and annul counter.
interface etapa_escritura_alu_if #(
    parameter int ancho = 32,
    parameter int dir   = 4
);
    logic             entrada_valida;
    logic             entrada_lista;
    logic [ancho-1:0] resultado;
    logic             N;
    logic             Z;
    logic             C;
    logic             V;
    logic [dir-1:0]   destino;
    logic             escribe_registro;
    logic             actualiza_banderas;
    logic [3:0]       condicion;
    logic             puerto_libre;
    logic             wr_en;
    logic [dir-1:0]   wr_dir;
    logic [ancho-1:0] wr_dato;
    logic [3:0]       banderas;
    logic [15:0]      contador_anuladas;

    modport master (
        output entrada_valida, resultado, N, Z, C, V,
        output destino, escribe_registro, actualiza_banderas,
        output condicion, puerto_libre,
        input  entrada_lista, wr_en, wr_dir, wr_dato,
        input  banderas, contador_anuladas
    );

    modport slave (
        input  entrada_valida, resultado, N, Z, C, V,
        input  destino, escribe_registro, actualiza_banderas,
        input  condicion, puerto_libre,
        output entrada_lista, wr_en, wr_dir, wr_dato,
        output banderas, contador_anuladas
    );
endinterface

// File: rtl/etapa_escritura_alu.sv
// ALU writeback stage: 2-entry in-order buffer, condition check at
// commit, shared register-file write port and NZCV flag register.
module etapa_escritura_alu #(
    parameter int ancho = 32,
    parameter int dir   = 4
) (
    input logic                   clk,
    input logic                   rst,
    etapa_escritura_alu_if.slave  bus
);
    typedef struct packed {
        logic [ancho-1:0] resultado;
        logic [3:0]       nzcv;
        logic [dir-1:0]   destino;
        logic             escribe;
        logic             actualiza;
        logic [3:0]       condicion;
    } entrada_t;

    entrada_t   fifo [2];
    logic       cabeza;
    logic       cola;
    logic [1:0] ocupacion;
    logic [3:0] banderas;
    logic       acepta;
    logic       condOk;
    logic       confirma;
    logic       escribeAhora;
    entrada_t   cab;

    function automatic logic evalua(
        input logic [3:0] c,
        input logic [3:0] f
    );
        logic n, z, k, v;
        logic r;
        {n, z, k, v} = f;
        r = 1'b0;
        case (c)
            4'd0:    r = z;
            4'd1:    r = !z;
            4'd2:    r = k;
            4'd3:    r = !k;
            4'd4:    r = n;
            4'd5:    r = !n;
            4'd6:    r = v;
            4'd7:    r = !v;
            4'd8:    r = k & !z;
            4'd9:    r = !k | z;
            4'd10:   r = (n == v);
            4'd11:   r = (n != v);
            4'd12:   r = !z & (n == v);
            4'd13:   r = z | (n != v);
            4'd14:   r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Handshake, condition check and commit decision for the head entry.
    always_comb begin
        cab = fifo[cabeza];
        bus.entrada_lista = !rst && (ocupacion != 2'd2);
        acepta = bus.entrada_valida && bus.entrada_lista;
        condOk = evalua(cab.condicion, banderas);
        escribeAhora = condOk && cab.escribe;
        confirma = (ocupacion != 2'd0)
                && (!escribeAhora || bus.puerto_libre);
    end

    assign bus.banderas = banderas;

    // Payload storage; contents are don't-care until marked occupied.
    always_ff @(posedge clk) begin
        if (acepta) begin
            fifo[cola] <= '{
                resultado: bus.resultado,
                nzcv:      {bus.N, bus.Z, bus.C, bus.V},
                destino:   bus.destino,
                escribe:   bus.escribe_registro,
                actualiza: bus.actualiza_banderas,
                condicion: bus.condicion
            };
        end
    end

    // Pointers, occupancy, flags, write port and annul counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cabeza                <= 1'b0;
            cola                  <= 1'b0;
            ocupacion             <= 2'd0;
            banderas              <= 4'b0000;
            bus.wr_en             <= 1'b0;
            bus.wr_dir            <= '0;
            bus.wr_dato           <= '0;
            bus.contador_anuladas <= 16'd0;
        end else begin
            bus.wr_en <= 1'b0;
            if (acepta) begin
                cola <= ~cola;
            end
            if (confirma) begin
                cabeza <= ~cabeza;
                if (escribeAhora) begin
                    bus.wr_en   <= 1'b1;
                    bus.wr_dir  <= cab.destino;
                    bus.wr_dato <= cab.resultado;
                end
                if (condOk && cab.actualiza) begin
                    banderas <= cab.nzcv;
                end
                if (!condOk) begin
                    bus.contador_anuladas <= bus.contador_anuladas + 16'd1;
                end
            end
            ocupacion <= ocupacion
                       + {1'b0, acepta}
                       - {1'b0, confirma};
        end
    end
endmodule

// File: tb/tb_etapa_escritura_alu.sv
// Directed bench for the ALU writeback stage.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_etapa_escritura_alu;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    etapa_escritura_alu_if #(.ancho(32), .dir(4)) bus ();

    etapa_escritura_alu #(.ancho(32), .dir(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(
        input string       tag,
        input logic [31:0] obs,
        input logic [31:0] exp
    );
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pon(
        input logic        v,
        input logic [31:0] res,
        input logic [3:0]  nzcv,
        input logic [3:0]  dst,
        input logic        esc,
        input logic        act,
        input logic [3:0]  cnd
    );
        bus.entrada_valida     = v;
        bus.resultado          = res;
        {bus.N, bus.Z, bus.C, bus.V} = nzcv;
        bus.destino            = dst;
        bus.escribe_registro   = esc;
        bus.actualiza_banderas = act;
        bus.condicion          = cnd;
    endtask

    task automatic nada();
        pon(1'b0, 32'h0, 4'h0, 4'h0, 1'b0, 1'b0, 4'd14);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        nada();
        bus.puerto_libre = 1'b1;
        #1;
        chk("lista_en_reset", {31'b0, bus.entrada_lista}, 32'd0);
        ciclo();
        ciclo();
        rst = 1'b0;
        #1;
        chk("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("rst_banderas", {28'b0, bus.banderas}, 32'd0);
        chk("rst_contador", {16'b0, bus.contador_anuladas}, 32'd0);
        chk("rst_wr_dir", {28'b0, bus.wr_dir}, 32'd0);
        chk("rst_lista", {31'b0, bus.entrada_lista}, 32'd1);

        // single op, AL, writes r3 and sets Z
        pon(1'b1, 32'h2A, 4'b0100, 4'd3, 1'b1, 1'b1, 4'd14);
        ciclo();
        nada();
        chk("t1_wr_en_k", {31'b0, bus.wr_en}, 32'd0);
        ciclo();
        chk("t1_wr_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t1_wr_dir", {28'b0, bus.wr_dir}, 32'd3);
        chk("t1_wr_dato", bus.wr_dato, 32'h2A);
        chk("t1_banderas", {28'b0, bus.banderas}, 32'h4);
        ciclo();
        chk("t1_wr_en_fin", {31'b0, bus.wr_en}, 32'd0);

        // conditional chain: AL sets Z, then NE is annulled
        pon(1'b1, 32'h11, 4'b0100, 4'd1, 1'b1, 1'b1, 4'd14);
        ciclo();
        pon(1'b1, 32'h55, 4'b0000, 4'd5, 1'b1, 1'b1, 4'd1);
        ciclo();
        nada();
        chk("t2_op1_wr_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t2_op1_dir", {28'b0, bus.wr_dir}, 32'd1);
        ciclo();
        chk("t2_op2_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("t2_anuladas", {16'b0, bus.contador_anuladas}, 32'd1);
        chk("t2_banderas", {28'b0, bus.banderas}, 32'h4);
        ciclo();
        chk("t2_wr_en_fin", {31'b0, bus.wr_en}, 32'd0);
        chk("t2_wr_dir_hold", {28'b0, bus.wr_dir}, 32'd1);

        // backpressure with the port busy
        bus.puerto_libre = 1'b0;
        pon(1'b1, 32'h70, 4'b0000, 4'd7, 1'b1, 1'b0, 4'd14);
        ciclo();
        pon(1'b1, 32'h80, 4'b0000, 4'd8, 1'b1, 1'b0, 4'd14);
        ciclo();
        pon(1'b1, 32'h90, 4'b0000, 4'd9, 1'b1, 1'b0, 4'd14);
        chk("t3_lleno", {31'b0, bus.entrada_lista}, 32'd0);
        ciclo();
        chk("t3_lleno2", {31'b0, bus.entrada_lista}, 32'd0);
        chk("t3_sin_wr", {31'b0, bus.wr_en}, 32'd0);
        bus.puerto_libre = 1'b1;
        ciclo();
        chk("t3_wr1_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t3_wr1_dir", {28'b0, bus.wr_dir}, 32'd7);
        chk("t3_wr1_dato", bus.wr_dato, 32'h70);
        chk("t3_lista", {31'b0, bus.entrada_lista}, 32'd1);
        ciclo();
        nada();
        chk("t3_wr2_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t3_wr2_dir", {28'b0, bus.wr_dir}, 32'd8);
        ciclo();
        chk("t3_wr3_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t3_wr3_dir", {28'b0, bus.wr_dir}, 32'd9);
        chk("t3_wr3_dato", bus.wr_dato, 32'h90);
        ciclo();
        chk("t3_fin", {31'b0, bus.wr_en}, 32'd0);

        // signed compare: N=1 V=0 then LT writes, GE annuls
        pon(1'b1, 32'h0, 4'b1000, 4'd0, 1'b0, 1'b1, 4'd14);
        ciclo();
        pon(1'b1, 32'hAA, 4'b0000, 4'd10, 1'b1, 1'b0, 4'd11);
        ciclo();
        pon(1'b1, 32'hBB, 4'b0000, 4'd11, 1'b1, 1'b0, 4'd10);
        chk("t4_banderas", {28'b0, bus.banderas}, 32'h8);
        chk("t4_x_sin_wr", {31'b0, bus.wr_en}, 32'd0);
        ciclo();
        nada();
        chk("t4_lt_en", {31'b0, bus.wr_en}, 32'd1);
        chk("t4_lt_dir", {28'b0, bus.wr_dir}, 32'd10);
        chk("t4_lt_dato", bus.wr_dato, 32'hAA);
        ciclo();
        chk("t4_ge_en", {31'b0, bus.wr_en}, 32'd0);
        chk("t4_ge_anul", {16'b0, bus.contador_anuladas}, 32'd2);
        chk("t4_dir_hold", {28'b0, bus.wr_dir}, 32'd10);

        // reset while two writing ops wait for the port
        bus.puerto_libre = 1'b0;
        pon(1'b1, 32'hC1, 4'b0010, 4'd12, 1'b1, 1'b1, 4'd14);
        ciclo();
        pon(1'b1, 32'hC2, 4'b0010, 4'd13, 1'b1, 1'b1, 4'd14);
        ciclo();
        nada();
        chk("t5_lleno", {31'b0, bus.entrada_lista}, 32'd0);
        rst = 1'b1;
        bus.puerto_libre = 1'b1;
        #1;
        chk("t5_lista_rst", {31'b0, bus.entrada_lista}, 32'd0);
        ciclo();
        rst = 1'b0;
        #1;
        chk("t5_wr_en", {31'b0, bus.wr_en}, 32'd0);
        chk("t5_banderas", {28'b0, bus.banderas}, 32'd0);
        chk("t5_contador", {16'b0, bus.contador_anuladas}, 32'd0);
        chk("t5_wr_dato", bus.wr_dato, 32'd0);
        chk("t5_lista", {31'b0, bus.entrada_lista}, 32'd1);
        ciclo();
        chk("t5_sin_wr", {31'b0, bus.wr_en}, 32'd0);
        ciclo();
        chk("t5_sin_wr2", {31'b0, bus.wr_en}, 32'd0);

        // annul counter wrap: 65535 NV ops, then one more
        pon(1'b1, 32'h0, 4'b1111, 4'd2, 1'b0, 1'b1, 4'd15);
        for (int i = 0; i < 65535; i++) begin
            ciclo();
        end
        nada();
        ciclo();
        ciclo();
        chk("t6_ffff", {16'b0, bus.contador_anuladas}, 32'hFFFF);
        chk("t6_banderas", {28'b0, bus.banderas}, 32'd0);
        pon(1'b1, 32'h0, 4'b1111, 4'd2, 1'b1, 1'b1, 4'd15);
        ciclo();
        nada();
        ciclo();
        ciclo();
        chk("t6_wrap", {16'b0, bus.contador_anuladas}, 32'd0);
        chk("t6_sin_wr", {31'b0, bus.wr_en}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/etapa_escritura_alu.md
Name: etapa_escritura_alu

Overview:
- Writeback stage directly downstream of the ALU. Accepts each ALU result and its NZCV flags through a valid/ready handshake, and buffers up to 2 pending operations.
- Evaluates each operation's 4-bit condition code against the architectural flag register at commit. Then either writes the result to the register-file write port and updates the flags, or annuls the operation.
- The register-file write port is shared, so a commit that writes stalls until the port is free.

Parameters:
- ancho, 32, width of result and write data
- dir, 4, register-file address width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- entrada_valida  input  1  upstream operation present this cycle
- entrada_lista  output  1  stage can accept this cycle
- resultado  input  ancho  ALU result
- N, Z, C, V  input  1 each  ALU flags for this operation
- destino  input  dir  destination register address
- escribe_registro  input  1  operation writes the register file
- actualiza_banderas  input  1  operation updates NZCV
- condicion  input  4  condition code
- puerto_libre  input  1  register-file write port available this cycle
- wr_en  output  1  register-file write strobe
- wr_dir  output  dir  register-file write address
- wr_dato  output  ancho  register-file write data
- banderas  output  4  architectural flags {N,Z,C,V}
- contador_anuladas  output  16  count of annulled operations

Behaviour:
- Reset:
  - Synchronous; rst high at an edge forces: ocupacion=0, banderas=4'b0000, wr_en=0, wr_dir=0, wr_dato=0, contador_anuladas=0.
  - Buffered entries are discarded, including any commit pending in the same cycle.
  - entrada_lista=0 while rst is high.
- Buffer:
  - 2-entry in-order FIFO (head/tail pointers, occupancy 0..2); pointers wrap mod 2.
  - entrada_lista = !rst && ocupacion!=2. It depends on registered occupancy only, never combinationally on puerto_libre or commit.
  - Accept when entrada_valida && entrada_lista; all input fields are captured at that edge.
- Condition evaluation (head entry vs current banderas):
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL true; 15 NV false.
- Commit (head entry, when ocupacion>0):
  - cond_ok && escribe_registro: commits only when puerto_libre=1; otherwise the head holds and nothing changes.
  - cond_ok && !escribe_registro: commits unconditionally.
  - !cond_ok: commits unconditionally as annulled. No write, no flag update, contador_anuladas+1 (wraps 0xFFFF->0).
  - On commit with cond_ok && actualiza_banderas: banderas <= head {N,Z,C,V}. The new value is visible to the next head's condition in the following cycle.
- Write outputs:
  - Registered. wr_en=1 for exactly the cycle after a writing commit edge, with wr_dir/wr_dato from that entry.
  - wr_en=0 otherwise; wr_dir/wr_dato hold their last values.
- Latency:
  - Operation accepted at edge k becomes head at the earliest in cycle k→k+1.
  - Earliest commit is at edge k+1, with wr_en high in cycle k+1→k+2.
  - At most one commit per cycle; sustained throughput is 1 op/cycle with puerto_libre=1.
- Simultaneous events:
  - Accept and commit in the same cycle: ocupacion unchanged, and the accepted entry goes behind the head.
  - Commit while full frees a slot; entrada_lista rises the next cycle.
  - Accept while empty does not commit that same edge.

Test Plan:
- Reset then single op: resultado=0x0000002A, destino=3, escribe=1, actualiza=1, NZCV=0100, cond=14, puerto_libre=1 → wr_en=1, wr_dir=3, wr_dato=0x2A exactly 2 cycles after valid; banderas=0100.
- Conditional chain: op1 sets Z=1 (cond AL), op2 cond=1 (NE) writes r5 → op2 annulled, no wr_en for r5, contador_anuladas=1, banderas stays 0100.
- Backpressure: puerto_libre=0, 3 back-to-back writing ops → 2 accepted, entrada_lista=0 with third held. Release port → writes occur in order on consecutive cycles, then third accepted.
- Signed compare: banderas N=1,V=0, op cond=11 (LT) writes → write occurs; cond=10 (GE) → annulled.
- Reset mid-operation: 2 entries buffered, puerto_libre=0, assert rst one cycle → no wr_en afterward, ocupacion=0, banderas=0000, entrada_lista=1 the cycle after rst deasserts.
- Counter wrap: preload contador_anuladas to 0xFFFF via 65535 cond=15 ops, one more → contador_anuladas=0x0000.
